// File: rtl/regs_ctx_pkg.sv
// Shared types for the thread-context scheduler: FSM states, bus widths and
// the per-slot context payload.
package regs_ctx_pkg;

  localparam int unsigned REG_BITS  = 256;
  localparam int unsigned PC_BITS   = 32;
  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned NREGS     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_SAVE   = 3'd4,
    ST_RETIRE = 3'd5
  } state_e;

  typedef struct packed {
    logic [REG_BITS-1:0] regs;
    logic [PC_BITS-1:0]  pc;
  } ctx_t;

endpackage

// File: rtl/regs_ctx_sched_if.sv
// Bundle of the work-queue, register-file and core signals around the
// context scheduler; master is the scheduler side.
interface regs_ctx_sched_if #(
  parameter int unsigned NCTX = 4
);
  import regs_ctx_pkg::*;

  localparam int unsigned SW = $clog2(NCTX);

  logic                ctx_in_valid;
  logic                ctx_in_ready;
  logic [REG_BITS-1:0] ctx_in_regs;
  logic [PC_BITS-1:0]  ctx_in_pc;
  logic                writing_regs;
  logic [REG_BITS-1:0] change_me;
  logic                give_me;
  logic [REG_BITS-1:0] the_regs;
  logic                core_stall;
  logic                core_start;
  logic [PC_BITS-1:0]  core_pc;
  logic                core_done;
  logic [PC_BITS-1:0]  core_pc_cur;
  logic                ctx_out_valid;
  logic                ctx_out_ready;
  logic [REG_BITS-1:0] ctx_out_regs;
  logic [PC_BITS-1:0]  ctx_out_pc;
  logic [SW-1:0]       active_slot;
  logic                busy;

  modport master (
    input  ctx_in_valid, ctx_in_regs, ctx_in_pc, the_regs, core_done,
           core_pc_cur, ctx_out_ready,
    output ctx_in_ready, writing_regs, change_me, give_me, core_stall,
           core_start, core_pc, ctx_out_valid, ctx_out_regs, ctx_out_pc,
           active_slot, busy
  );

  modport slave (
    output ctx_in_valid, ctx_in_regs, ctx_in_pc, the_regs, core_done,
           core_pc_cur, ctx_out_ready,
    input  ctx_in_ready, writing_regs, change_me, give_me, core_stall,
           core_start, core_pc, ctx_out_valid, ctx_out_regs, ctx_out_pc,
           active_slot, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational first-set search over vec, starting one past index last and
// wrapping; N must be a power of two.
module rr_pick #(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = last + W'(i + 1);
      if (!found && vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/regs_ctx_sched.sv
// Round-robin time-slice scheduler multiplexing one register file between
// NCTX saved contexts (regs 0-7 plus PC per slot).
module regs_ctx_sched #(
  parameter int unsigned NCTX  = 4,
  parameter int unsigned SLICE = 16,
  parameter int unsigned DRAIN = 2
) (
  input logic             clk,
  input logic             reset,
  regs_ctx_sched_if.master bus
);
  import regs_ctx_pkg::*;

  localparam int unsigned SW = $clog2(NCTX);
  localparam int unsigned CW = $clog2(SLICE);
  localparam int unsigned DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  state_e              state_q, state_d;
  ctx_t                slot_q [NCTX];
  ctx_t                slot_d [NCTX];
  logic [NCTX-1:0]     valid_q, valid_d;
  logic [SW-1:0]       last_q, last_d;
  logic [SW-1:0]       active_q, active_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic                done_q, done_d;

  logic                ctx_in_ready_q, ctx_in_ready_d;
  logic                writing_regs_q, writing_regs_d;
  logic [REG_BITS-1:0] change_me_q, change_me_d;
  logic                give_me_q, give_me_d;
  logic                core_stall_q, core_stall_d;
  logic                core_start_q, core_start_d;
  logic [PC_BITS-1:0]  core_pc_q, core_pc_d;
  logic                ctx_out_valid_q, ctx_out_valid_d;
  logic [REG_BITS-1:0] ctx_out_regs_q, ctx_out_regs_d;
  logic [PC_BITS-1:0]  ctx_out_pc_q, ctx_out_pc_d;
  logic                busy_q, busy_d;

  logic                pick_found, free_found, in_fire;
  logic [SW-1:0]       pick_idx, free_idx;

  // Dispatch choice rotates from the last dispatched slot.
  rr_pick #(.N(NCTX)) u_pick (
    .vec   (valid_q),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Starting after NCTX-1 makes the search begin at slot 0: lowest free slot.
  rr_pick #(.N(NCTX)) u_free (
    .vec   (~valid_q),
    .last  (SW'(NCTX - 1)),
    .found (free_found),
    .idx   (free_idx)
  );

  assign in_fire = bus.ctx_in_valid && ctx_in_ready_q && free_found;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    valid_d  = valid_q;
    last_d   = last_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    dcnt_d   = dcnt_q;
    done_d   = done_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          active_d = pick_idx;
          last_d   = pick_idx;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = CW'(SLICE - 1);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Completion takes priority over slice expiry in the same cycle.
        if (bus.core_done || cnt_q == '0) begin
          slot_d[active_q].pc = bus.core_pc_cur;
          done_d              = bus.core_done;
          dcnt_d              = DW'(DRAIN - 1);
          state_d             = ST_DRAIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == '0) state_d = ST_SAVE;
        else              dcnt_d  = dcnt_q - DW'(1);
      end
      ST_SAVE: begin
        slot_d[active_q].regs = bus.the_regs;
        state_d               = done_q ? ST_RETIRE : ST_IDLE;
      end
      ST_RETIRE: begin
        if (bus.ctx_out_ready) begin
          valid_d[active_q] = 1'b0;
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Enqueue targets a slot invalid in valid_q, so it never collides with
    // the active slot being saved or retired.
    if (in_fire) begin
      valid_d[free_idx] = 1'b1;
      slot_d[free_idx]  = '{regs: bus.ctx_in_regs, pc: bus.ctx_in_pc};
    end

    // Outputs are registered versions of what the next state presents.
    writing_regs_d  = (state_d == ST_LOAD);
    change_me_d     = writing_regs_d ? slot_d[active_d].regs : '0;
    core_stall_d    = state_d inside {ST_LOAD, ST_DRAIN, ST_SAVE, ST_RETIRE};
    give_me_d       = state_d inside {ST_DRAIN, ST_SAVE};
    core_start_d    = (state_q == ST_LOAD);
    core_pc_d       = core_start_d ? slot_d[active_d].pc : '0;
    ctx_out_valid_d = (state_d == ST_RETIRE);
    ctx_out_regs_d  = ctx_out_valid_d ? slot_d[active_d].regs : '0;
    ctx_out_pc_d    = ctx_out_valid_d ? slot_d[active_d].pc : '0;
    ctx_in_ready_d  = ~&valid_d;
    busy_d          = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      for (int unsigned i = 0; i < NCTX; i++) slot_q[i] <= '0;
      valid_q  <= '0;
      last_q   <= SW'(NCTX - 1);
      active_q <= '0;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      done_q   <= 1'b0;

      ctx_in_ready_q  <= 1'b1;
      writing_regs_q  <= 1'b0;
      change_me_q     <= '0;
      give_me_q       <= 1'b0;
      core_stall_q    <= 1'b0;
      core_start_q    <= 1'b0;
      core_pc_q       <= '0;
      ctx_out_valid_q <= 1'b0;
      ctx_out_regs_q  <= '0;
      ctx_out_pc_q    <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      done_q   <= done_d;

      ctx_in_ready_q  <= ctx_in_ready_d;
      writing_regs_q  <= writing_regs_d;
      change_me_q     <= change_me_d;
      give_me_q       <= give_me_d;
      core_stall_q    <= core_stall_d;
      core_start_q    <= core_start_d;
      core_pc_q       <= core_pc_d;
      ctx_out_valid_q <= ctx_out_valid_d;
      ctx_out_regs_q  <= ctx_out_regs_d;
      ctx_out_pc_q    <= ctx_out_pc_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.ctx_in_ready  = ctx_in_ready_q;
  assign bus.writing_regs  = writing_regs_q;
  assign bus.change_me     = change_me_q;
  assign bus.give_me       = give_me_q;
  assign bus.core_stall    = core_stall_q;
  assign bus.core_start    = core_start_q;
  assign bus.core_pc       = core_pc_q;
  assign bus.ctx_out_valid = ctx_out_valid_q;
  assign bus.ctx_out_regs  = ctx_out_regs_q;
  assign bus.ctx_out_pc    = ctx_out_pc_q;
  assign bus.active_slot   = active_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_regs_ctx_sched.sv
// Bench for regs_ctx_sched: emulated register file with one-cycle snapshot lag,
// a context-level reference model, directed scenarios and random traffic.
module tb_regs_ctx_sched;
  import regs_ctx_pkg::*;

  localparam int unsigned NCTX  = 4;
  localparam int unsigned SLICE = 16;
  localparam int unsigned DRAIN = 2;

  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DRAIN = 3, P_SAVE = 4, P_RETIRE = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  regs_ctx_sched_if #(.NCTX(NCTX)) bus ();

  regs_ctx_sched #(.NCTX(NCTX), .SLICE(SLICE), .DRAIN(DRAIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Register file seen by the core: bulk load, core writes while running, lagged snapshot.
  logic [255:0] rf     = '0;
  logic [255:0] rf_lag = '0;
  logic         core_wr = 1'b0;
  logic [2:0]   core_wr_idx = '0;
  logic [31:0]  core_wr_data = '0;

  always @(posedge clk) begin
    if (bus.writing_regs) rf <= bus.change_me;
    else if (core_wr && bus.busy && !bus.core_stall)
      rf[255 - 32*int'(core_wr_idx) -: 32] <= core_wr_data;
    rf_lag <= rf;
  end
  assign bus.the_regs = rf_lag;

  // Context-level reference model.
  logic [255:0] m_regs [NCTX];
  logic [31:0]  m_pc   [NCTX];
  bit           m_valid[NCTX];
  int           m_phase = P_IDLE;
  int           m_slot  = 0;
  int           m_last  = NCTX - 1;
  int           m_age   = 0;
  int           m_dage  = 0;
  bit           m_done  = 1'b0;
  bit           m_live  = 1'b0;
  logic [255:0] m_snap  = '0;

  function automatic int lowest_free();
    for (int i = 0; i < NCTX; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int rr_next();
    for (int k = 1; k <= NCTX; k++) if (m_valid[(m_last + k) % NCTX]) return (m_last + k) % NCTX;
    return -1;
  endfunction

  always @(posedge clk) begin : model_b
    int fr;
    int pk;
    if (reset) begin
      for (int i = 0; i < NCTX; i++) begin
        m_valid[i] = 1'b0;
        m_regs[i]  = '0;
        m_pc[i]    = '0;
      end
      m_phase = P_IDLE;
      m_slot  = 0;
      m_last  = NCTX - 1;
    end else begin
      fr = lowest_free();
      case (m_phase)
        P_IDLE: begin
          pk = rr_next();
          if (pk >= 0) begin
            m_slot  = pk;
            m_last  = pk;
            m_phase = P_LOAD;
          end
        end
        P_LOAD: begin
          m_phase = P_RUN;
          m_age   = 0;
        end
        P_RUN: begin
          if (bus.core_done || m_age == SLICE - 1) begin
            m_pc[m_slot] = bus.core_pc_cur;
            m_done       = bus.core_done;
            m_phase      = P_DRAIN;
            m_dage       = 0;
          end else m_age++;
        end
        P_DRAIN: begin
          // The core is frozen from here on, so the file already holds the final RUN state.
          if (m_dage == 0) m_snap = rf;
          if (m_dage == DRAIN - 1) m_phase = P_SAVE;
          else m_dage++;
        end
        P_SAVE: begin
          m_regs[m_slot] = m_snap;
          m_phase        = m_done ? P_RETIRE : P_IDLE;
        end
        P_RETIRE: begin
          if (bus.ctx_out_ready) begin
            m_valid[m_slot] = 1'b0;
            m_phase         = P_IDLE;
          end
        end
        default: m_phase = P_IDLE;
      endcase
      if (bus.ctx_in_valid && fr >= 0) begin
        m_valid[fr] = 1'b1;
        m_regs[fr]  = bus.ctx_in_regs;
        m_pc[fr]    = bus.ctx_in_pc;
      end
    end
    m_live = 1'b1;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("ctx_in_ready", 256'(bus.ctx_in_ready), 256'(lowest_free() >= 0));
      chk("busy", 256'(bus.busy), 256'(m_phase != P_IDLE));
      chk("active_slot", 256'(bus.active_slot), 256'(m_slot));
      chk("writing_regs", 256'(bus.writing_regs), 256'(m_phase == P_LOAD));
      chk("change_me", bus.change_me, (m_phase == P_LOAD) ? m_regs[m_slot] : 256'(0));
      chk("core_start", 256'(bus.core_start), 256'(m_phase == P_RUN && m_age == 0));
      chk("core_pc", 256'(bus.core_pc), (m_phase == P_RUN && m_age == 0) ? 256'(m_pc[m_slot]) : 256'(0));
      chk("core_stall", 256'(bus.core_stall),
          256'(m_phase inside {P_LOAD, P_DRAIN, P_SAVE, P_RETIRE}));
      chk("give_me", 256'(bus.give_me), 256'(m_phase inside {P_DRAIN, P_SAVE}));
      chk("ctx_out_valid", 256'(bus.ctx_out_valid), 256'(m_phase == P_RETIRE));
      chk("ctx_out_regs", bus.ctx_out_regs, (m_phase == P_RETIRE) ? m_regs[m_slot] : 256'(0));
      chk("ctx_out_pc", 256'(bus.ctx_out_pc), (m_phase == P_RETIRE) ? 256'(m_pc[m_slot]) : 256'(0));
    end
  end

  function automatic bit sig(input int sel);
    case (sel)
      0:       return bus.writing_regs;
      1:       return bus.ctx_out_valid;
      default: return bus.give_me;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input string tag);
    int n = 0;
    while (!sig(sel) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!sig(sel)) chk({tag, "_timeout"}, 256'(sig(sel)), 256'(1));
  endtask

  // Counts RUN cycles from the current (running) negedge; on the last one applies the given core action.
  task automatic run_slice(input bit do_write, input bit do_done, input logic [31:0] pc_cur, output int n);
    n = 0;
    while (!bus.core_stall && n < 100) begin
      n++;
      if (n == SLICE) begin
        core_wr          = do_write;
        core_wr_idx      = 3'd3;
        core_wr_data     = 32'h0000_DEAD;
        bus.core_done    = do_done;
        bus.core_pc_cur  = pc_cur;
      end
      @(negedge clk);
      core_wr       = 1'b0;
      bus.core_done = 1'b0;
    end
  endtask

  logic [255:0] r1, r1dead;
  int           n;

  initial begin
    r1     = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    r1dead = {32'd1, 32'd2, 32'd3, 32'h0000_DEAD, 32'd5, 32'd6, 32'd7, 32'd8};
    bus.ctx_in_valid  = 1'b0;
    bus.ctx_in_regs   = '0;
    bus.ctx_in_pc     = '0;
    bus.core_done     = 1'b0;
    bus.core_pc_cur   = '0;
    bus.ctx_out_ready = 1'b0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 256'(bus.ctx_in_ready), 256'(1));
    chk("rst_busy", 256'(bus.busy), 256'(0));
    chk("rst_stall", 256'(bus.core_stall), 256'(0));
    chk("rst_out_valid", 256'(bus.ctx_out_valid), 256'(0));

    // Single context: load, run a full slice, preempt, re-dispatch with the snapshot.
    bus.ctx_in_valid = 1'b1;
    bus.ctx_in_regs  = r1;
    bus.ctx_in_pc    = 32'h40;
    @(negedge clk);
    bus.ctx_in_valid = 1'b0;
    wait_sig(0, "load1");
    chk("load1_data", bus.change_me, r1);
    @(negedge clk);
    chk("start1", 256'(bus.core_start), 256'(1));
    chk("start1_pc", 256'(bus.core_pc), 256'(32'h40));
    run_slice(1'b1, 1'b0, 32'h1234, n);
    chk("slice1_len", 256'(n), 256'(SLICE));
    wait_sig(0, "load2");
    chk("load2_snapshot", bus.change_me, r1dead);
    @(negedge clk);
    chk("start2_pc", 256'(bus.core_pc), 256'(32'h1234));

    // Completion on the last slice cycle: retires, held while consumer stalls.
    run_slice(1'b0, 1'b1, 32'h77, n);
    chk("slice2_len", 256'(n), 256'(SLICE));
    wait_sig(1, "retire");
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 256'(bus.ctx_out_valid), 256'(1));
      chk("hold_regs", bus.ctx_out_regs, r1dead);
      chk("hold_pc", 256'(bus.ctx_out_pc), 256'(32'h77));
      @(negedge clk);
    end
    bus.ctx_out_ready = 1'b1;
    @(negedge clk);
    bus.ctx_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("retired_idle", 256'(bus.busy), 256'(0));
      @(negedge clk);
    end

    // Fill every slot; an extra offer must be refused.
    for (int i = 0; i < NCTX; i++) begin
      bus.ctx_in_valid = 1'b1;
      bus.ctx_in_regs  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.ctx_in_pc    = 32'(i * 256);
      @(negedge clk);
    end
    chk("full_ready", 256'(bus.ctx_in_ready), 256'(0));
    bus.ctx_in_pc = 32'hBAD0;
    repeat (5) @(negedge clk);
    bus.ctx_in_valid = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      bus.ctx_in_valid  = ($urandom % 3) == 0;
      bus.ctx_in_regs   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.ctx_in_pc     = $urandom;
      bus.core_done     = ($urandom % 20) == 0;
      bus.core_pc_cur   = $urandom;
      bus.ctx_out_ready = ($urandom % 2) == 0;
      core_wr           = ($urandom % 2) == 0;
      core_wr_idx       = 3'($urandom);
      core_wr_data      = $urandom;
      @(negedge clk);
    end
    bus.ctx_in_valid  = 1'b0;
    bus.core_done     = 1'b0;
    bus.ctx_out_ready = 1'b1;
    core_wr           = 1'b0;

    // Reset in the middle of DRAIN abandons everything.
    if (bus.ctx_in_ready) begin
      bus.ctx_in_valid = 1'b1;
      @(negedge clk);
      bus.ctx_in_valid = 1'b0;
    end
    wait_sig(2, "drain");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstdrain_busy", 256'(bus.busy), 256'(0));
    chk("rstdrain_stall", 256'(bus.core_stall), 256'(0));
    chk("rstdrain_out_valid", 256'(bus.ctx_out_valid), 256'(0));
    chk("rstdrain_ready", 256'(bus.ctx_in_ready), 256'(1));
    repeat (3) @(negedge clk);
    chk("rstdrain_no_slots", 256'(bus.busy), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regs_ctx_sched.md
Name: regs_ctx_sched

Overview:
Thread-context scheduler that time-multiplexes the single register file between up to NCTX software contexts. It holds saved snapshots of regs 0-7 plus PC for each context. It round-robin dispatches one context to the core, bulk-loads its registers, and runs it for a time slice. On slice expiry or completion it stalls the core, captures the register file, and saves or retires the context. It sits between the work-queue front end and the core/register-file pair.

Parameters:
NCTX, 4, number of context slots (power of 2, >=2)
SLICE, 16, run cycles per dispatch before preemption (>=2)
DRAIN, 2, stall cycles before capture; covers the one-cycle-lagged snapshot bus

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ctx_in_valid  in  1  new context offered
ctx_in_ready  out  1  a free slot exists
ctx_in_regs  in  256  initial regs 0-7, reg0 in bits [255:224]
ctx_in_pc  in  32  initial PC
writing_regs  out  1  bulk-load strobe to register file
change_me  out  256  bulk-load data, same packing as ctx_in_regs
give_me  out  1  snapshot request; high in DRAIN and SAVE
the_regs  in  256  register-file snapshot, lags writes by one cycle
core_stall  out  1  freezes core and all register/predicate writes
core_start  out  1  one-cycle pulse, first RUN cycle
core_pc  out  32  dispatch PC, valid while core_start is high
core_done  in  1  running context finished; sampled only in RUN
core_pc_cur  in  32  core's current PC, saved on preemption
ctx_out_valid  out  1  finished context available
ctx_out_ready  in  1  consumer accepts
ctx_out_regs  out  256  final regs 0-7
ctx_out_pc  out  32  final PC
active_slot  out  $clog2(NCTX)  slot being dispatched, run or saved
busy  out  1  state != IDLE

Behaviour:
- Reset:
  - All slot valid bits cleared; state IDLE; last_slot = NCTX-1, so the first pick is slot 0.
  - All outputs 0 except ctx_in_ready, which is 1 from the first post-reset cycle.
  - Reset mid-operation abandons the running context; no save occurs.
- Enqueue:
  - ctx_in_ready = any slot free (registered valid bits).
  - On valid&&ready, data is written to the lowest free slot and the slot becomes valid next cycle. Accepted in any state.
  - A slot freed by a retire this cycle is not offered until next cycle.
- IDLE:
  - If any slot is valid, pick the first valid slot searching from (last_slot+1) mod NCTX with wrap-around.
  - Set active_slot and last_slot, then go to LOAD. Otherwise stay.
- LOAD (1 cycle):
  - writing_regs=1, change_me=slot regs, core_stall=1.
  - Next state RUN; slice counter = SLICE-1.
- RUN:
  - First cycle: core_start=1, core_pc=slot PC.
  - core_stall=0; counter decrements each cycle.
  - core_done=1 → DRAIN with done flag set.
  - counter==0 → DRAIN with done flag clear (preempt).
  - If both occur in the same cycle, done wins.
  - On exit, latch core_pc_cur into the slot PC.
- DRAIN (DRAIN cycles):
  - core_stall=1, give_me=1, then go to SAVE.
  - Guarantees the_regs reflects the last write made in RUN.
- SAVE (1 cycle):
  - core_stall=1; slot regs <= the_regs.
  - Done flag clear → IDLE; the slot stays valid and re-enters round robin.
  - Done flag set → RETIRE.
- RETIRE:
  - ctx_out_valid=1 with the slot's regs/PC, stable until accepted.
  - On ctx_out_ready, clear the slot's valid bit and go to IDLE.
  - core_stall stays 1.
- Single valid context: it is preempted and immediately re-dispatched (IDLE, LOAD, RUN).
- Dispatch overhead: IDLE→RUN is 2 cycles. Preemption overhead is 1+DRAIN+1 cycles.
- Bus packing: the block never alters bit packing; bits pass through slot storage unchanged.

Decomposition:
- Package regs_ctx_pkg:
  - state enum {IDLE, LOAD, RUN, DRAIN, SAVE, RETIRE}
  - REG_BITS=256, PC_BITS=32
  - ctx_t struct {regs, pc}
- Sub-module rr_pick: combinational round-robin first-valid search (valid vector, last index → found, index). Reused by the lowest-free-slot finder with a fixed start of 0.

Test Plan:
- Reset then enqueue one context (regs=0x00000001..0x00000008, pc=0x40), no core_done:
  - writing_regs pulses with change_me equal to those regs.
  - core_start pulses with core_pc=0x40.
  - Preemption after 16 RUN cycles.
  - Slot 0 is re-dispatched with the_regs snapshot and core_pc_cur saved.
- Enqueue 3 contexts:
  - Dispatch order is slot 0,1,2,0.
  - Retire slot 1 via core_done; the order becomes 0,2,0,2.
- core_done on the final slice cycle (counter==0):
  - Context retires, not re-queued.
  - ctx_out_valid held 5 cycles with ctx_out_ready=0; data stable throughout.
- Fill all 4 slots:
  - ctx_in_ready=0; an extra offer is not accepted.
  - After a retire handshake, ctx_in_ready=1 one cycle later and the new context lands in the freed slot.
- Core writes reg3=0xDEAD on the last RUN cycle:
  - Saved snapshot word 3 = 0xDEAD.
  - Verifies the DRAIN length covers the snapshot lag.
- Reset asserted during DRAIN:
  - Next cycle state IDLE, all slots invalid, core_stall=0, ctx_out_valid=0.
